// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared funct3 codes, FSM states and access sizes for the load/store unit
package mem_lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    function automatic size_e f3_size(input logic [2:0] f3);
        return (f3 == F3_B || f3 == F3_BU) ? SZ_BYTE :
               (f3 == F3_H || f3 == F3_HU) ? SZ_HALF : SZ_WORD;
    endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/acknowledge bus between the load/store unit and data memory
interface mem_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master(output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_ack, mem_rdata);
    modport slave(input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and lane extraction with sign/zero extension for loads
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  st_off_i,
    input  size_e       st_size_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,
    input  logic [1:0]  ld_off_i,
    input  size_e       ld_size_i,
    input  logic        ld_signed_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);
    logic [7:0]  b;
    logic [15:0] h;

    // halves pick their lane from bit 1 only, so an odd half address folds onto its aligned half
    always_comb begin
        st_be_o   = st_size_i == SZ_BYTE ? 4'b0001 << st_off_i :
                    st_size_i == SZ_HALF ? (st_off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        st_data_o = st_size_i == SZ_BYTE ? {4{st_data_i[7:0]}} :
                    st_size_i == SZ_HALF ? {2{st_data_i[15:0]}} : st_data_i;
        b         = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
        h         = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        ld_data_o = ld_size_i == SZ_BYTE ? {{24{ld_signed_i & b[7]}}, b} :
                    ld_size_i == SZ_HALF ? {{16{ld_signed_i & h[15]}}, h} : ld_rdata_i;
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with req/ack memory handshake; MEM_LSU_MISALIGN_TRAP_EN enables misalignment trapping
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    mem_lsu_if.master   mem,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        err_misalign_o,
    output logic        err_timeout_o
);
    state_e      state_q;
    size_e       size_d, size_q;
    logic        accept_d, mis_d, req_q, we_q, sign_q, done_q, emis_q, eto_q;
    logic [1:0]  off_q;
    logic [3:0]  be_q, st_be;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q, wdata_q, ld_q, st_data, ld_data;

    assign size_d   = f3_size(funct3_i);
    assign accept_d = in_valid_i & (is_load_i | is_store_i);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign mis_d = (size_d == SZ_HALF && addr_i[0]) || (size_d == SZ_WORD && addr_i[1:0] != 2'b00);
`else
    assign mis_d = 1'b0;
`endif

    lsu_align u_align (
        .st_off_i   (addr_i[1:0]),
        .st_size_i  (size_d),
        .st_data_i  (wdata_i),
        .st_be_o    (st_be),
        .st_data_o  (st_data),
        .ld_off_i   (off_q),
        .ld_size_i  (size_q),
        .ld_signed_i(sign_q),
        .ld_rdata_i (mem.mem_rdata),
        .ld_data_o  (ld_data)
    );

    // access FSM: capture at accept, hold the request until ack or timeout, then pulse done for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            done_q  <= 1'b0;
            ld_q    <= '0;
            emis_q  <= 1'b0;
            eto_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept_d) begin
                    we_q    <= is_store_i;
                    addr_q  <= {addr_i[31:2], 2'b00};
                    be_q    <= is_store_i ? st_be : 4'b1111;
                    wdata_q <= is_store_i ? st_data : '0;
                    off_q   <= addr_i[1:0];
                    size_q  <= size_d;
                    sign_q  <= ~funct3_i[2];
                    cnt_q   <= '0;
                    ld_q    <= '0;
                    state_q <= mis_d ? S_RESP : S_BUSY;
                    req_q   <= ~mis_d;
                    done_q  <= mis_d;
                    emis_q  <= mis_d;
                end
                S_BUSY: if (mem.mem_ack) begin
                    state_q <= S_RESP;
                    req_q   <= 1'b0;
                    done_q  <= 1'b1;
                    ld_q    <= we_q ? '0 : ld_data;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_q <= S_RESP;
                    req_q   <= 1'b0;
                    done_q  <= 1'b1;
                    eto_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    ld_q    <= '0;
                    emis_q  <= 1'b0;
                    eto_q   <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o        = (state_q == S_IDLE && accept_d) || state_q == S_BUSY;
    assign done_o         = done_q;
    assign load_data_o    = ld_q;
    assign err_misalign_o = emis_q;
    assign err_timeout_o  = eto_q;
    assign mem.mem_req    = req_q;
    assign mem.mem_we     = we_q;
    assign mem.mem_addr   = addr_q;
    assign mem.mem_be     = be_q;
    assign mem.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu; a second instance with TIMEOUT=4 covers the timeout path
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    typedef struct packed {
        logic [7:0]  done_cyc;
        logic [7:0]  req_lo;
        logic [7:0]  req_hi;
        logic [31:0] ld;
        logic        emis;
        logic        eto;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic        stable;
        logic        stall_ok;
    } bus_t;

    typedef struct {
        string       name;
        logic        t;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          ack;
        resp_t       er;
        bus_t        eb;
    } case_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0, in_valid_t = 0, is_load = 0, is_store = 0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, done, emis, eto, stall_t, done_t, emis_t, eto_t;
    logic [31:0] ld_data, ld_data_t;
    resp_t       sb[$];
    int          n_tests = 0, n_fail = 0;

    mem_lsu_if mb();
    mem_lsu_if mt();

    mem_lsu dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .is_load_i(is_load), .is_store_i(is_store),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .mem(mb), .stall_o(stall), .done_o(done),
        .load_data_o(ld_data), .err_misalign_o(emis), .err_timeout_o(eto)
    );

    mem_lsu #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_t), .is_load_i(is_load), .is_store_i(is_store),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .mem(mt), .stall_o(stall_t), .done_o(done_t),
        .load_data_o(ld_data_t), .err_misalign_o(emis_t), .err_timeout_o(eto_t)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic resp_t rsp(input int dc, lo, hi, input logic [31:0] ld, input logic em, et);
        return '{done_cyc: 8'(dc), req_lo: 8'(lo), req_hi: 8'(hi), ld: ld, emis: em, eto: et};
    endfunction

    function automatic bus_t bus(input logic [31:0] a, wd, input logic [3:0] be, input logic we);
        return '{addr: a, wdata: wd, be: be, we: we, stable: 1'b1, stall_ok: 1'b1};
    endfunction

    // one access starting next cycle (cycle 0 = accept); memory acks in cycle ack (-1 = never)
    task automatic run(input case_t c, output resp_t r, output bus_t b);
        logic req, dn, stl, mwe;
        logic [31:0] ma, mw;
        logic [3:0]  mbe;
        r = rsp(-1, -1, -1, '0, 1'b0, 1'b0);
        b = bus('0, '0, '0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            in_valid     = !c.t && k == 0;
            in_valid_t   = c.t && k == 0;
            is_load      = c.ld;
            is_store     = c.st;
            funct3       = c.f3;
            addr         = c.a;
            wdata        = c.wd;
            mb.mem_ack   = !c.t && k == c.ack;
            mt.mem_ack   = c.t && k == c.ack;
            mb.mem_rdata = c.rd;
            mt.mem_rdata = c.rd;
            @(negedge clk);
            req = c.t ? mt.mem_req : mb.mem_req;
            mwe = c.t ? mt.mem_we : mb.mem_we;
            ma  = c.t ? mt.mem_addr : mb.mem_addr;
            mw  = c.t ? mt.mem_wdata : mb.mem_wdata;
            mbe = c.t ? mt.mem_be : mb.mem_be;
            dn  = c.t ? done_t : done;
            stl = c.t ? stall_t : stall;
            if (req) begin
                if (r.req_lo == 8'hFF) begin
                    r.req_lo = 8'(k);
                    b.addr = ma; b.be = mbe; b.we = mwe; b.wdata = mwe ? mw : '0;
                end else if ({ma, mbe, mwe} !== {b.addr, b.be, b.we} || (mwe && mw !== b.wdata)) begin
                    b.stable = 1'b0;
                end
                r.req_hi = 8'(k);
            end
            if (dn) begin
                r.done_cyc = 8'(k);
                r.ld   = c.t ? ld_data_t : ld_data;
                r.emis = c.t ? emis_t : emis;
                r.eto  = c.t ? eto_t : eto;
                if (stl) b.stall_ok = 1'b0;
                break;
            end
            if (!stl) b.stall_ok = 1'b0;
        end
        mb.mem_ack = 1'b0;
        mt.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({stall, done, ld_data, emis, eto, stall_t, done_t, ld_data_t, emis_t, eto_t} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %h exp 0", {stall, done, ld_data, emis, eto, stall_t, done_t, ld_data_t, emis_t, eto_t});
        end
        n_tests++;
        if ({mb.mem_req, mb.mem_we, mb.mem_addr, mb.mem_be, mb.mem_wdata, mt.mem_req, mt.mem_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus got %h exp 0", {mb.mem_req, mb.mem_we, mb.mem_addr, mb.mem_be, mb.mem_wdata, mt.mem_req, mt.mem_addr});
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_loads();
        case_t cs[3];
        resp_t r, e;
        bus_t  b;
        cs[0] = '{"lb",  1'b0, 1'b1, 1'b0, F3_B,  32'h1003, 32'h0, 32'h80FF_0000, 1,
                  rsp(2, 1, 1, 32'hFFFF_FF80, 1'b0, 1'b0), bus(32'h1000, '0, 4'hF, 1'b0)};
        cs[1] = '{"lbu", 1'b0, 1'b1, 1'b0, F3_BU, 32'h1003, 32'h0, 32'h80FF_0000, 1,
                  rsp(2, 1, 1, 32'h0000_0080, 1'b0, 1'b0), bus(32'h1000, '0, 4'hF, 1'b0)};
        cs[2] = '{"lw_slow", 1'b0, 1'b1, 1'b0, F3_W, 32'h3000, 32'h0, 32'hCAFE_F00D, 5,
                  rsp(6, 1, 5, 32'hCAFE_F00D, 1'b0, 1'b0), bus(32'h3000, '0, 4'hF, 1'b0)};
        foreach (cs[i]) begin
            sb.push_back(cs[i].er);
            run(cs[i], r, b);
            e = sb.pop_front();
            n_tests++;
            if (r !== e) begin n_fail++; $display("FAIL %s resp got %h exp %h", cs[i].name, r, e); end
            n_tests++;
            if (b !== cs[i].eb) begin n_fail++; $display("FAIL %s bus got %h exp %h", cs[i].name, b, cs[i].eb); end
        end
    endtask

    task automatic test_stores();
        case_t cs[2];
        resp_t r, e;
        bus_t  b;
        cs[0] = '{"sh", 1'b0, 1'b0, 1'b1, F3_H, 32'h2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 3,
                  rsp(4, 1, 3, '0, 1'b0, 1'b0), bus(32'h2000, 32'hABCD_ABCD, 4'b1100, 1'b1)};
        cs[1] = '{"store_wins", 1'b0, 1'b1, 1'b1, F3_W, 32'h6000, 32'h0102_0304, 32'hFFFF_FFFF, 1,
                  rsp(2, 1, 1, '0, 1'b0, 1'b0), bus(32'h6000, 32'h0102_0304, 4'hF, 1'b1)};
        foreach (cs[i]) begin
            sb.push_back(cs[i].er);
            run(cs[i], r, b);
            e = sb.pop_front();
            n_tests++;
            if (r !== e) begin n_fail++; $display("FAIL %s resp got %h exp %h", cs[i].name, r, e); end
            n_tests++;
            if (b !== cs[i].eb) begin n_fail++; $display("FAIL %s bus got %h exp %h", cs[i].name, b, cs[i].eb); end
        end
    endtask

    task automatic test_timeout();
        case_t c;
        resp_t r, e;
        bus_t  b;
        c = '{"timeout", 1'b1, 1'b1, 1'b0, F3_W, 32'h7000, 32'h0, 32'h1111_1111, -1,
              rsp(5, 1, 4, '0, 1'b0, 1'b1), bus(32'h7000, '0, 4'hF, 1'b0)};
        sb.push_back(c.er);
        run(c, r, b);
        e = sb.pop_front();
        n_tests++;
        if (r !== e) begin n_fail++; $display("FAIL %s resp got %h exp %h", c.name, r, e); end
        n_tests++;
        if (b !== c.eb) begin n_fail++; $display("FAIL %s bus got %h exp %h", c.name, b, c.eb); end
    endtask

    task automatic test_misalign();
        case_t cs[2];
        resp_t r, e;
        bus_t  b;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        cs[0] = '{"lw_mis", 1'b0, 1'b1, 1'b0, F3_W, 32'h4002, 32'h0, 32'h1122_3344, 1,
                  rsp(1, -1, -1, '0, 1'b1, 1'b0), bus('0, '0, '0, 1'b0)};
        cs[1] = '{"lh_mis", 1'b0, 1'b1, 1'b0, F3_H, 32'h4003, 32'h0, 32'h8001_0000, 2,
                  rsp(1, -1, -1, '0, 1'b1, 1'b0), bus('0, '0, '0, 1'b0)};
`else
        cs[0] = '{"lw_mis", 1'b0, 1'b1, 1'b0, F3_W, 32'h4002, 32'h0, 32'h1122_3344, 1,
                  rsp(2, 1, 1, 32'h1122_3344, 1'b0, 1'b0), bus(32'h4000, '0, 4'hF, 1'b0)};
        cs[1] = '{"lh_mis", 1'b0, 1'b1, 1'b0, F3_H, 32'h4003, 32'h0, 32'h8001_0000, 2,
                  rsp(3, 1, 2, 32'hFFFF_8001, 1'b0, 1'b0), bus(32'h4000, '0, 4'hF, 1'b0)};
`endif
        foreach (cs[i]) begin
            sb.push_back(cs[i].er);
            run(cs[i], r, b);
            e = sb.pop_front();
            n_tests++;
            if (r !== e) begin n_fail++; $display("FAIL %s resp got %h exp %h", cs[i].name, r, e); end
            n_tests++;
            if (b !== cs[i].eb) begin n_fail++; $display("FAIL %s bus got %h exp %h", cs[i].name, b, cs[i].eb); end
        end
    endtask

    task automatic test_back_to_back();
        case_t cs[3];
        resp_t r, e;
        bus_t  b;
        cs[0] = '{"b2b_sb", 1'b0, 1'b0, 1'b1, F3_B, 32'h0011, 32'h0000_00A5, 32'h0, 1,
                  rsp(2, 1, 1, '0, 1'b0, 1'b0), bus(32'h0010, 32'hA5A5_A5A5, 4'b0010, 1'b1)};
        cs[1] = '{"b2b_lh", 1'b0, 1'b1, 1'b0, F3_H, 32'h0022, 32'h0, 32'hBEEF_0000, 1,
                  rsp(2, 1, 1, 32'hFFFF_BEEF, 1'b0, 1'b0), bus(32'h0020, '0, 4'hF, 1'b0)};
        cs[2] = '{"b2b_lhu", 1'b0, 1'b1, 1'b0, F3_HU, 32'h0022, 32'h0, 32'hBEEF_0000, 1,
                  rsp(2, 1, 1, 32'h0000_BEEF, 1'b0, 1'b0), bus(32'h0020, '0, 4'hF, 1'b0)};
        foreach (cs[i]) sb.push_back(cs[i].er);
        foreach (cs[i]) begin
            run(cs[i], r, b);
            e = sb.pop_front();
            n_tests++;
            if (r !== e) begin n_fail++; $display("FAIL %s resp got %h exp %h", cs[i].name, r, e); end
            n_tests++;
            if (b !== cs[i].eb) begin n_fail++; $display("FAIL %s bus got %h exp %h", cs[i].name, b, cs[i].eb); end
        end
    endtask

    task automatic test_reset_busy();
        logic busy2, late;
        @(posedge clk); #1;
        in_valid = 1; is_load = 1; is_store = 0; funct3 = F3_W; addr = 32'h5000;
        mb.mem_ack = 0;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        busy2 = mb.mem_req;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_tests++;
        if ({busy2, mb.mem_req, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_busy req2/req3/done got %b exp 100", {busy2, mb.mem_req, done});
        end
        late = 0;
        for (int k = 4; k < 10; k++) begin
            @(posedge clk); #1;
            mb.mem_ack = k == 4;
            mb.mem_rdata = 32'h5555_AAAA;
            @(negedge clk);
            if (mb.mem_req || done || stall || ld_data != 0) late = 1;
        end
        mb.mem_ack = 0;
        n_tests++;
        if (late !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack got %b exp 0", late); end
    endtask

    initial begin
        mb.mem_ack = 0; mb.mem_rdata = '0;
        mt.mem_ack = 0; mt.mem_rdata = '0;
        test_reset();
        test_loads();
        test_stores();
        test_timeout();
        test_misalign();
        test_back_to_back();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
